fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect control, instruction-memory read port and
// the decoded-side valid/ready output stream. master = fetch_queue, slave = consumer/memory.
interface fetch_queue_if #(
    parameter int AW = 9,
    parameter int IW = 9
);
    logic [AW-1:0] start_addr;
    logic          redirect;
    logic [AW-1:0] target;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          halted;

    modport master (
        input  start_addr, redirect, target, mem_data, out_ready,
        output mem_rd, mem_addr, out_valid, out_pc, out_instr, halted
    );

    modport slave (
        output start_addr, redirect, target, mem_data, out_ready,
        input  mem_rd, mem_addr, out_valid, out_pc, out_instr, halted
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding memory read, DEPTH-entry FIFO of {pc, instr}.
// Optional halt detection is compiled in with the FETCH_HALT_EN macro.
module fetch_queue #(
    parameter int            AW         = 9,
    parameter int            IW         = 9,
    parameter int            DEPTH      = 4,
    parameter logic [IW-1:0] HALT_INSTR = '1
) (
    input  logic           clk,
    input  logic           start,
    fetch_queue_if.master  bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || $bits(HALT_INSTR) != IW) begin : g_bad_cfg
        $error("fetch_queue: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0] fpc_q, fpc_d;
    logic [AW-1:0] ipc_q, ipc_d;
    logic          infl_q, infl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] pc_mem_q    [DEPTH];
    logic [IW-1:0] instr_mem_q [DEPTH];

    logic          issue, push, pop, halt_block;
    logic [CW:0]   occ;

    // Slots already promised to the in-flight read count as occupied, so a
    // returning response always finds room even if nobody pops that cycle.
    always_comb begin
        occ   = {1'b0, cnt_q} + (CW + 1)'(infl_q);
        issue = !start && !bus.redirect && !halt_block && (occ < {1'b0, FULL});
        push  = infl_q && !bus.redirect && !start;
        pop   = bus.out_valid && bus.out_ready;
    end

    always_comb begin
        fpc_d    = fpc_q;
        ipc_d    = ipc_q;
        infl_d   = issue;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.redirect) begin
            fpc_d    = bus.target;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                fpc_d = fpc_q + 1'b1;
                ipc_d = fpc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            fpc_q    <= bus.start_addr;
            ipc_q    <= '0;
            infl_q   <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            fpc_q    <= fpc_d;
            ipc_q    <= ipc_d;
            infl_q   <= infl_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= ipc_q;
            instr_mem_q[wr_ptr_q] <= bus.mem_data;
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_q, halted_d, halt_hit;

    // The halting response also blocks the issue that would overlap it.
    always_comb begin
        halt_hit   = push && (bus.mem_data == HALT_INSTR);
        halted_d   = bus.redirect ? 1'b0 : (halted_q || halt_hit);
        halt_block = halted_q || halt_hit;
    end

    always_ff @(posedge clk) begin
        if (start) halted_q <= 1'b0;
        else       halted_q <= halted_d;
    end

    assign bus.halted = halted_q;
`else
    assign halt_block = 1'b0;
    assign bus.halted = 1'b0;
`endif

    // Output stream: out_pc/out_instr are meaningful only while out_valid;
    // an entry leaves the queue on any edge where out_valid && out_ready.
    assign bus.mem_rd    = issue;
    assign bus.mem_addr  = fpc_q;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_pc    = pc_mem_q[rd_ptr_q];
    assign bus.out_instr = instr_mem_q[rd_ptr_q];
endmodule
